// File: rtl/led_ring_monitor_pkg.sv
// Shared definitions for the LED ring monitor: FSM encoding and the ring rotation helper.
package led_ring_monitor_pkg;

    localparam int MAX_LEDS = 64;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    // Rotate the low n bits of v left by one; bits above n are returned as zero.
    function automatic logic [MAX_LEDS-1:0] rotl(input logic [MAX_LEDS-1:0] v, input int unsigned n);
        logic [MAX_LEDS-1:0] mask;
        mask = (n >= MAX_LEDS) ? '1 : ((MAX_LEDS'(1) << n) - MAX_LEDS'(1));
        return ((v << 1) | (v >> (n - 1))) & mask;
    endfunction

endpackage

// File: rtl/led_ring_monitor_onehot_decoder.sv
// Combinational one-hot check and binary position decode of the observed LED bus.
module onehot_decoder #(
    parameter int NB_LEDS  = 4,
    parameter int NB_INDEX = 2
) (
    input  logic [NB_LEDS-1:0]  led,
    output logic                is_onehot,
    output logic [NB_INDEX-1:0] idx
);

    always_comb begin
        is_onehot = (led != '0) && ((led & (led - NB_LEDS'(1))) == '0);
        idx       = '0;
        for (int i = 0; i < NB_LEDS; i++) begin
            if (led[i]) idx = NB_INDEX'(i);
        end
    end

endmodule

// File: rtl/led_ring_monitor.sv
// Receive-side checker for the one-hot rotating LED ring: locks on, decodes the
// lit position and flags any step that is not a single left rotation.
module led_ring_monitor
    import led_ring_monitor_pkg::*;
#(
    parameter int NB_LEDS   = 4,
    parameter int NB_INDEX  = 2,
    parameter int NB_ERRCNT = 8
) (
    input  logic                 clock,
    input  logic                 i_reset,
    input  logic [NB_LEDS-1:0]   i_led,
    input  logic                 i_valid,
    input  logic                 i_clear,
    output logic [NB_INDEX-1:0]  o_index,
    output logic                 o_locked,
    output logic                 o_wrap,
    output logic                 o_error,
    output logic [NB_ERRCNT-1:0] o_err_count
);

    state_t               state;
    logic [NB_LEDS-1:0]   exp_led;
    logic                 valid_d;
    logic                 is_onehot;
    logic [NB_INDEX-1:0]  idx;
    logic [NB_LEDS-1:0]   req_led;
    logic                 at_last;

    onehot_decoder #(
        .NB_LEDS  (NB_LEDS),
        .NB_INDEX (NB_INDEX)
    ) u_decoder (
        .led       (i_led),
        .is_onehot (is_onehot),
        .idx       (idx)
    );

    // The rotator shows a strobed step one cycle late, so compare against the delayed strobe.
    always_comb begin
        req_led = valid_d ? NB_LEDS'(rotl(MAX_LEDS'(exp_led), NB_LEDS)) : exp_led;
        at_last = (o_index == NB_INDEX'(NB_LEDS - 1));
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state       <= UNLOCKED;
            exp_led     <= '0;
            valid_d     <= 1'b0;
            o_index     <= '0;
            o_locked    <= 1'b0;
            o_wrap      <= 1'b0;
            o_error     <= 1'b0;
            o_err_count <= '0;
        end else begin
            valid_d <= i_valid;
            o_wrap  <= 1'b0;
            o_error <= 1'b0;
            if (i_clear) begin
                state       <= UNLOCKED;
                o_locked    <= 1'b0;
                o_err_count <= '0;
            end else begin
                case (state)
                    UNLOCKED: begin
                        if (is_onehot) begin
                            state    <= LOCKED;
                            exp_led  <= i_led;
                            o_index  <= idx;
                            o_locked <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (i_led == req_led) begin
                            exp_led <= i_led;
                            if (valid_d) begin
                                o_index <= at_last ? '0 : o_index + NB_INDEX'(1);
                                o_wrap  <= at_last;
                            end
                        end else begin
                            state    <= UNLOCKED;
                            o_locked <= 1'b0;
                            o_error  <= 1'b1;
                            if (o_err_count != '1) o_err_count <= o_err_count + NB_ERRCNT'(1);
                        end
                    end
                    default: state <= UNLOCKED;
                endcase
            end
        end
    end

endmodule

// File: doc/led_ring_monitor.md
Name: led_ring_monitor

Overview:
- Receiving-end checker for the one-hot rotating LED ring driven by the LED rotator.
- Observes the LED bus and the same advance strobe that drives the rotator.
- Locks onto the pattern, decodes the lit position to a binary index, and flags any step that is not a single left-rotation.
- Sits beside the rotator on the board top; its outputs feed debug LEDs or an ILA.

Parameters:
- NB_LEDS, 4, width of the observed LED bus; must be ≥ 2.
- NB_INDEX, 2, width of the decoded index; equals clog2(NB_LEDS).
- NB_ERRCNT, 8, width of the saturating error counter.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_led  input  NB_LEDS  observed LED bus, registered by the rotator.
- i_valid  input  1  advance strobe, same signal that drives the rotator.
- i_clear  input  1  synchronous; clears the error counter and forces UNLOCKED.
- o_index  output  NB_INDEX  bit position of the lit LED while locked.
- o_locked  output  1  high while tracking a consistent pattern.
- o_wrap  output  1  one-cycle pulse when the index steps from NB_LEDS-1 to 0.
- o_error  output  1  one-cycle pulse on a detected protocol violation.
- o_err_count  output  NB_ERRCNT  saturating count of violations.

Behaviour:
- Reset (i_reset low, asynchronous):
  - state = UNLOCKED.
  - o_index, o_locked, o_wrap, o_error, o_err_count all 0.
  - Internal expected pattern = 0.
  - valid_d = 0.
- Timing alignment:
  - The rotator updates on the edge where i_valid is high, so the new pattern is visible one cycle later.
  - valid_d <= i_valid every cycle. The checker uses valid_d, not i_valid.
- One-hot detect (combinational): exactly one bit of i_led set. idx = position of that bit.
- UNLOCKED:
  - If i_led is one-hot: next state LOCKED; exp <= i_led; o_index <= idx; o_locked <= 1.
  - Otherwise: stay UNLOCKED. No error is raised while unlocked.
  - valid_d is ignored in this state.
- LOCKED, valid_d = 1:
  - Required i_led = rotl(exp) = {exp[NB_LEDS-2:0], exp[NB_LEDS-1]}.
  - On match: exp <= i_led; o_index <= (o_index == NB_LEDS-1) ? 0 : o_index+1.
  - o_wrap = 1 for one cycle when the index moves from NB_LEDS-1 to 0.
- LOCKED, valid_d = 0: required i_led = exp (pattern must hold).
- Violation (any mismatch while LOCKED):
  - o_error = 1 for one cycle.
  - o_err_count += 1, saturating at all-ones.
  - state -> UNLOCKED; o_locked <= 0; o_index holds its last value.
  - Relock is possible no earlier than the following cycle.
- i_clear = 1:
  - state -> UNLOCKED; o_err_count <= 0; o_error and o_wrap forced 0.
  - i_clear has priority over a simultaneous violation: the count ends at 0 and no error pulse is emitted.
- Rotator synchronous reset mid-run: its pattern jumps to bit0 without a strobe and is reported as a violation. Software pulses i_clear alongside the rotator reset to avoid counting it.
- Back-to-back i_valid on every cycle: supported. Each cycle checks one rotation.
- Latency: o_index and o_locked update 1 cycle after the pattern appears on i_led. o_error and o_wrap are registered and appear in that same cycle.
- Width rule: o_index increments modulo NB_LEDS, not modulo 2^NB_INDEX.

Decomposition:
- Shared package: FSM state encoding (UNLOCKED=0, LOCKED=1) and the rotl helper function.
- One sub-module, onehot_decoder: i_led -> {is_onehot, idx}. It is purely combinational and parameterized by NB_LEDS / NB_INDEX.
- FSM, error counter and wrap logic stay in led_ring_monitor.

Test Plan:
- Reset release, i_led=0001, no strobe -> o_locked=1 next cycle, o_index=0, o_error=0.
- Locked on 0001; i_valid pulses producing 0010, 0100, 1000, 0001 -> o_index 1, 2, 3, 0; o_wrap=1 only on the 3->0 step; o_error never set.
- Locked on 0010; i_led forced to 0100 with no strobe -> o_error pulse, o_err_count=1, o_locked=0, relock on the following cycle.
- Locked on 0100; strobe but i_led shows 0001 -> o_error pulse, o_err_count increments.
- i_led=0110 or 0000 while unlocked -> stays unlocked, no error. Drive 255+ violations -> o_err_count saturates at 8'hFF.
- Violation and i_clear in the same cycle -> o_err_count=0, o_error=0, UNLOCKED. Assert i_reset low mid-run -> all outputs 0 immediately, without waiting for a clock edge.
